// File: rtl/seg7_num_entry.sv
// seg7_num_entry: debounced push-button entry of a 4-digit BCD value with a
// cursor, plus a multi-cycle BCD-to-binary converter that runs on commit.
//
// Five raw buttons are synchronized and debounced. A press event is a
// one-cycle pulse on the debounced 0->1 edge. Events edit the BCD digits or
// move the cursor while the converter is idle. The center button snapshots
// the digits and starts the conversion.
//
// Output handshake: num/num_valid carry no backpressure. num_valid is high
// for exactly one cycle, and num is already valid in that same cycle. num
// then holds its value until the next commit or reset. A consumer that
// needs the value must capture it on the num_valid cycle or read num at
// any later time.
module seg7_num_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clock_100,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [15:0] digits,
  output logic [1:0]  cursor,
  output logic        busy,
  output logic [13:0] num,
  output logic        num_valid,
  output logic [1:0]  conv_state
);

  // Bit order of the button vectors below.
  localparam int B_UP     = 0;
  localparam int B_DOWN   = 1;
  localparam int B_LEFT   = 2;
  localparam int B_RIGHT  = 3;
  localparam int B_CENTER = 4;

  // Terminal count: a level is accepted on the DEBOUNCE_CYCLES-th
  // consecutive disagreeing cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [4:0]       raw;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       db;
  logic [4:0]       db_q;
  logic [4:0]       press;
  logic [CNT_W-1:0] cnt [5];

  state_t           state;
  logic [15:0]      shadow;
  logic [1:0]       idx;
  logic [13:0]      acc;
  logic [13:0]      acc_next;
  logic [3:0]       sel_digit;
  logic [3:0]       sel_inc;
  logic [3:0]       sel_dec;
  logic [3:0]       conv_digit;

  assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchronizers, one per raw button.
  always_ff @(posedge clock_100) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncers: the counter runs while the synchronized input disagrees
  // with the accepted level and clears on any agreeing cycle.
  always_ff @(posedge clock_100) begin
    if (!reset) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // A press is the cycle right after the debounced level rises. A release
  // produces no event.
  assign press = db & ~db_q;

  // Digit under the cursor, and its wrapped increment and decrement.
  assign sel_digit = digits[{cursor, 2'b00} +: 4];
  assign sel_inc   = (sel_digit == 4'd9) ? 4'd0 : sel_digit + 4'd1;
  assign sel_dec   = (sel_digit == 4'd0) ? 4'd9 : sel_digit - 4'd1;

  // Multiply-accumulate step: acc*10 + digit, with *10 done as x8 + x2.
  // The result is at most 9999, so 14 bits never overflow.
  assign conv_digit = shadow[{idx, 2'b00} +: 4];
  assign acc_next   = (acc << 3) + (acc << 1) + {10'd0, conv_digit};

  assign busy       = (state != IDLE);
  assign conv_state = state;

  // Edit and convert FSM. Events are taken only in IDLE, one per cycle,
  // in priority center > up > down > left > right. Events that arrive
  // while busy are dropped.
  always_ff @(posedge clock_100) begin
    if (!reset) begin
      state     <= IDLE;
      digits    <= '0;
      cursor    <= '0;
      shadow    <= '0;
      idx       <= '0;
      acc       <= '0;
      num       <= '0;
      num_valid <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (press[B_CENTER]) begin
            shadow <= digits;
            acc    <= '0;
            idx    <= 2'd3;
            state  <= CONV;
          end else if (press[B_UP]) begin
            digits[{cursor, 2'b00} +: 4] <= sel_inc;
          end else if (press[B_DOWN]) begin
            digits[{cursor, 2'b00} +: 4] <= sel_dec;
          end else if (press[B_LEFT]) begin
            cursor <= cursor + 2'd1;
          end else if (press[B_RIGHT]) begin
            cursor <= cursor - 2'd1;
          end
        end
        CONV: begin
          acc <= acc_next;
          if (idx == 2'd0) begin
            // Publish on entry to DONE so that num and num_valid are both
            // valid during the DONE cycle.
            num       <= acc_next;
            num_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seg7_num_entry.md
# seg7_num_entry

Button-driven 4-digit decimal entry block: the input-side counterpart of the generation-count 7-segment display driver. It debounces five board push-buttons and lets the user edit a 4-digit BCD value with a cursor. On commit it converts the BCD value to a 14-bit binary number (0-9999) with a multi-cycle multiply-accumulate FSM. It sits between the board buttons and the core: the BCD digits feed the display driver, and the committed binary value feeds the core (e.g. generation target).

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level (10 ms at 100 MHz); minimum 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

- clock_100  in  1  system clock, 100 MHz; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clock_100 rising edge
- btn_up  in  1  raw asynchronous button: increment selected digit
- btn_down  in  1  raw asynchronous button: decrement selected digit
- btn_left  in  1  raw asynchronous button: move cursor toward thousands
- btn_right  in  1  raw asynchronous button: move cursor toward ones
- btn_center  in  1  raw asynchronous button: commit
- digits  out  16  edit BCD value, [15:12] thousands … [3:0] ones
- cursor  out  2  selected digit, 0 = ones … 3 = thousands
- busy  out  1  high while conversion FSM is not IDLE
- num  out  14  last committed binary value
- num_valid  out  1  one-cycle pulse when num updates

## Operation
- Per button: 2-flop synchronizer, then debouncer. Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
- Press event: single-cycle pulse on debounced 0->1 transition. Release produces no event.
- Events are acted on only in IDLE; events arriving while busy are dropped, not queued.
- Same-cycle events: priority center > up > down > left > right; lower-priority events in that cycle are dropped.
- up: selected digit +1, 9 wraps to 0, no carry into the neighbour digit. down: 0 wraps to 9, no borrow.
- left: cursor +1 mod 4 (3 -> 0). right: cursor -1 mod 4 (0 -> 3).
- center: snapshot digits into a shadow register, acc = 0, go to CONV.
- FSM states: IDLE -> CONV (exactly 4 cycles, idx 3 down to 0, acc <= acc*10 + shadow[idx]) -> DONE (num <= acc, num_valid = 1) -> IDLE.
- Arithmetic: acc is 14 bits; maximum 9999 < 16384, so no overflow. *10 is implemented as (acc<<3)+(acc<<1). Digit values are always 0-9 by construction.
- digits and cursor are unaffected by commit; the user may continue editing afterwards.

## Timing
- Reset (reset = 0 at an edge): digits = 0, cursor = 0, num = 0, num_valid = 0, busy = 0, state IDLE, debounced levels = 0, debounce counters = 0, synchronizers = 0. Reset mid-conversion aborts it; num stays 0 and there is no num_valid pulse.
- Button to event: a raw edge held stable yields an event DEBOUNCE_CYCLES + 2 to + 3 cycles later (synchronizer plus counter).
- Edit latency: event in cycle N -> digits/cursor updated at the N+1 edge.
- Commit latency: center event in cycle N; busy high cycles N+1..N+5 (CONV N+1..N+4, DONE N+5); num and num_valid valid in cycle N+5; busy low and IDLE in N+6. A new event is accepted from N+6.
- num_valid is high for exactly 1 cycle per commit; num holds its value until the next commit or reset.
- Bounce shorter than DEBOUNCE_CYCLES produces no event; a held button produces exactly one event.

## Test plan
- Use DEBOUNCE_CYCLES = 4 for all scenarios.
- Reset: hold reset low 3 cycles with all buttons toggling -> digits = 0x0000, cursor = 0, num = 0, num_valid never high.
- Edit/wrap: 3 up presses on ones, then left ×1, then 1 down -> digits = 0x0093. Left ×3 -> cursor = 0 (wrapped). Right from 0 -> cursor = 3.
- Commit: enter 0x9999, press center -> busy high exactly 5 cycles, num = 9999 (14'h270F), single num_valid pulse in the 5th busy cycle. Repeat with 0x0407 -> num = 407.
- Debounce: pulse btn_up high 3 cycles, bounce 5 times, then hold high 20 cycles -> exactly one increment.
- Simultaneous/busy: assert up and left on the same debounced cycle -> only the digit increments. Press up during busy -> ignored; digits unchanged.
- Reset mid-conversion: drive reset low in the 2nd CONV cycle -> num = 0, no num_valid pulse, busy = 0 after the edge.
